// File: rtl/seg_argmax.sv
// Per-pixel argmax over UNITS signed fixed-point class scores, using a pipelined
// comparison tree. Also keeps a per-frame histogram of the winning classes.
module seg_argmax #(
  parameter int W_HEIGHT  = 480,
  parameter int W_WIDTH   = 640,
  parameter int UNITS     = 12,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
  localparam int V_BITW     = $clog2(W_HEIGHT),
  localparam int H_BITW     = $clog2(W_WIDTH),
  localparam int CLS_BITW   = $clog2(UNITS),
  localparam int CNT_BITW   = V_BITW + H_BITW + 1
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           in_enable,
  input  logic [FIXED_BITW*UNITS-1:0]    in_y,
  input  logic [V_BITW-1:0]              in_vcnt,
  input  logic [H_BITW-1:0]              in_hcnt,
  output logic                           out_enable,
  output logic [CLS_BITW-1:0]            out_class,
  output logic [FIXED_BITW-1:0]          out_score,
  output logic [V_BITW-1:0]              out_vcnt,
  output logic [H_BITW-1:0]              out_hcnt,
  output logic [CNT_BITW*UNITS-1:0]      out_hist,
  output logic                           hist_valid
);

  // Candidate count per tree level: 12 -> 6 -> 3 -> 2 -> 1.
  localparam int N1 = (UNITS + 1) / 2;
  localparam int N2 = (N1 + 1) / 2;
  localparam int N3 = (N2 + 1) / 2;

  typedef struct packed {
    logic [CLS_BITW-1:0]          idx;
    logic signed [FIXED_BITW-1:0] score;
  } cand_t;

  // Padding always sits in the odd (higher) slot and never wins a strict compare,
  // so an odd candidate passes through its stage unchanged.
  localparam cand_t PAD = '{idx: '1, score: {1'b1, {(FIXED_BITW-1){1'b0}}}};

  // The lower-index candidate is always 'a'; it keeps ties.
  function automatic cand_t pick(input cand_t a, input cand_t b);
    return (b.score > a.score) ? b : a;
  endfunction

  cand_t lvl0_p [2*N1];
  cand_t lvl1_q [N1];
  cand_t lvl1_p [2*N2];
  cand_t lvl2_q [N2];
  cand_t lvl2_p [2*N3];
  cand_t lvl3_q [N3];
  cand_t lvl3_p [2];

  logic              vld_q [3];
  logic [V_BITW-1:0] vc_q  [3];
  logic [H_BITW-1:0] hc_q  [3];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 2*N1; i++) lvl0_p[i] = PAD;
    for (int i = 0; i < UNITS; i++)
      lvl0_p[i] = '{idx: CLS_BITW'(i), score: in_y[FIXED_BITW*(UNITS-i)-1 -: FIXED_BITW]};
    for (int i = 0; i < 2*N2; i++) lvl1_p[i] = PAD;
    for (int i = 0; i < N1; i++)   lvl1_p[i] = lvl1_q[i];
    for (int i = 0; i < 2*N3; i++) lvl2_p[i] = PAD;
    for (int i = 0; i < N2; i++)   lvl2_p[i] = lvl2_q[i];
    for (int i = 0; i < 2; i++)    lvl3_p[i] = PAD;
    for (int i = 0; i < N3; i++)   lvl3_p[i] = lvl3_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments only, so stage order never matters.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < N1; i++) lvl1_q[i] <= '0;
      for (int i = 0; i < N2; i++) lvl2_q[i] <= '0;
      for (int i = 0; i < N3; i++) lvl3_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        vld_q[i] <= 1'b0;
        vc_q[i]  <= '0;
        hc_q[i]  <= '0;
      end
      out_enable <= 1'b0;
      out_class  <= '0;
      out_score  <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
    end else begin
      for (int i = 0; i < N1; i++) lvl1_q[i] <= pick(lvl0_p[2*i], lvl0_p[2*i+1]);
      for (int i = 0; i < N2; i++) lvl2_q[i] <= pick(lvl1_p[2*i], lvl1_p[2*i+1]);
      for (int i = 0; i < N3; i++) lvl3_q[i] <= pick(lvl2_p[2*i], lvl2_p[2*i+1]);
      {out_class, out_score} <= pick(lvl3_p[0], lvl3_p[1]);
      vld_q[0] <= in_enable;
      vc_q[0]  <= in_vcnt;
      hc_q[0]  <= in_hcnt;
      for (int i = 1; i < 3; i++) begin
        vld_q[i] <= vld_q[i-1];
        vc_q[i]  <= vc_q[i-1];
        hc_q[i]  <= hc_q[i-1];
      end
      out_enable <= vld_q[2];
      out_vcnt   <= vc_q[2];
      out_hcnt   <= hc_q[2];
    end
  end

  logic [CNT_BITW-1:0] cnt_q [UNITS];
  logic [CNT_BITW-1:0] cnt_d [UNITS];
  logic                frame_start;
  logic                frame_end;

  // A (0,0) pixel restarts from zero before counting itself; counts saturate.
  always_comb begin
    frame_start = out_enable && (out_vcnt == '0) && (out_hcnt == '0);
    frame_end   = out_enable && (out_vcnt == V_BITW'(W_HEIGHT-1))
                             && (out_hcnt == H_BITW'(W_WIDTH-1));
    for (int u = 0; u < UNITS; u++) begin
      cnt_d[u] = frame_start ? '0 : cnt_q[u];
      if (out_enable && (out_class == CLS_BITW'(u)) && (cnt_d[u] != '1))
        cnt_d[u] = cnt_d[u] + CNT_BITW'(1);
    end
  end

  // NOTE: the counters are plain flops, not a RAM, so reset clears them all in one cycle.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int u = 0; u < UNITS; u++) cnt_q[u] <= '0;
      out_hist   <= '0;
      hist_valid <= 1'b0;
    end else begin
      hist_valid <= frame_end;
      for (int u = 0; u < UNITS; u++) begin
        if (frame_end) begin
          out_hist[CNT_BITW*(UNITS-u)-1 -: CNT_BITW] <= cnt_d[u];
          cnt_q[u] <= '0;
        end else begin
          cnt_q[u] <= cnt_d[u];
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_argmax.sv
// Directed bench for seg_argmax: table-driven argmax vectors, then streamed
// sequences for gaps, frames, back-to-back frames, mid-frame reset and saturation.
module tb_seg_argmax;
  localparam int UNITS = 12;
  localparam int FB    = 13;
  localparam int CB    = 4;
  localparam int NB    = 5;
  localparam int YW    = FB * UNITS;
  localparam int HW    = NB * UNITS;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          in_enable = 1'b0;
  logic [YW-1:0] in_y = '0;
  logic [1:0]    in_vcnt = '0;
  logic [1:0]    in_hcnt = '0;
  logic          out_enable;
  logic [CB-1:0] out_class;
  logic [FB-1:0] out_score;
  logic [1:0]    out_vcnt;
  logic [1:0]    out_hcnt;
  logic [HW-1:0] out_hist;
  logic          hist_valid;

  seg_argmax #(.W_HEIGHT(4), .W_WIDTH(4)) dut (
    .clock(clock), .rst(rst), .in_enable(in_enable), .in_y(in_y),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable),
    .out_class(out_class), .out_score(out_score), .out_vcnt(out_vcnt),
    .out_hcnt(out_hcnt), .out_hist(out_hist), .hist_valid(hist_valid)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [YW-1:0] put(input logic [YW-1:0] y, input int u, input logic [FB-1:0] v);
    y[FB*(UNITS-u)-1 -: FB] = v;
    return y;
  endfunction

  function automatic logic [YW-1:0] fill(input logic [FB-1:0] v);
    logic [YW-1:0] y;
    y = '0;
    for (int u = 0; u < UNITS; u++) y = put(y, u, v);
    return y;
  endfunction

  function automatic logic [HW-1:0] hput(input logic [HW-1:0] h, input int u, input logic [NB-1:0] v);
    h[NB*(UNITS-u)-1 -: NB] = v;
    return h;
  endfunction

  function automatic logic [YW-1:0] mk_y(input logic [CB-1:0] cls);
    return put(fill(13'h0000), int'(cls), 13'h0100);
  endfunction

  typedef struct {
    logic [YW-1:0] y;
    logic [CB-1:0] cls;
    logic [FB-1:0] score;
  } vec_t;

  typedef struct {
    logic          en;
    logic [1:0]    v;
    logic [1:0]    h;
    logic [CB-1:0] cls;
  } pix_t;

  vec_t          vt [8];
  pix_t          pq [$];
  int            pulses;
  logic [HW-1:0] h0, h1;

  task automatic add_pix(input logic en, input int v, input int h, input int cls);
    pix_t p;
    p.en = en; p.v = 2'(v); p.h = 2'(h); p.cls = CB'(cls);
    pq.push_back(p);
  endtask

  // mode 0: class=h; 1: class=4+v; 2: (0,0)->11 else 8; 3: all class 9
  task automatic add_frame(input int mode);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++)
        case (mode)
          0:       add_pix(1'b1, v, h, h);
          1:       add_pix(1'b1, v, h, 4 + v);
          2:       add_pix(1'b1, v, h, (v == 0 && h == 0) ? 11 : 8);
          default: add_pix(1'b1, v, h, 9);
        endcase
  endtask

  // Streams pq one pixel per cycle, checks each pixel 4 cycles later, records histogram pulses.
  task automatic run();
    pulses = 0; h0 = '0; h1 = '0;
    for (int c = 0; c < pq.size() + 6; c++) begin
      if (c < pq.size()) begin
        in_enable = pq[c].en; in_vcnt = pq[c].v; in_hcnt = pq[c].h; in_y = mk_y(pq[c].cls);
      end else begin
        in_enable = 1'b0;
      end
      @(posedge clock); #1;
      if (c >= 3) begin
        int j;
        j = c - 3;
        if (j < pq.size()) begin
          check("stream_enable", 64'(out_enable), 64'(pq[j].en));
          check("stream_vcnt", 64'(out_vcnt), 64'(pq[j].v));
          check("stream_hcnt", 64'(out_hcnt), 64'(pq[j].h));
          if (pq[j].en) check("stream_class", 64'(out_class), 64'(pq[j].cls));
        end else begin
          check("stream_idle_enable", 64'(out_enable), 64'd0);
        end
      end
      if (hist_valid) begin
        if (pulses == 0) h0 = out_hist;
        else if (pulses == 1) h1 = out_hist;
        pulses++;
      end
    end
    pq.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_enable"}, 64'(out_enable), 64'd0);
    check({tag, "_hist_valid"}, 64'(hist_valid), 64'd0);
    check({tag, "_class"}, 64'(out_class), 64'd0);
    check({tag, "_score"}, 64'(out_score), 64'd0);
    check({tag, "_vcnt"}, 64'(out_vcnt), 64'd0);
    check({tag, "_hcnt"}, 64'(out_hcnt), 64'd0);
    check({tag, "_hist"}, 64'(out_hist), 64'd0);
  endtask

  initial begin
    logic [HW-1:0] e0, e1;

    vt[0] = '{put(fill(13'h1F00), 7, 13'h0380), 4'd7, 13'h0380};
    vt[1] = '{put(put(fill(13'h0000), 2, 13'h0100), 9, 13'h0100), 4'd2, 13'h0100};
    vt[2] = '{fill(13'h1000), 4'd0, 13'h1000};
    vt[3] = '{fill(13'h0000), 4'd0, 13'h0000};
    vt[4] = '{put(fill(13'h0000), 11, 13'h0001), 4'd11, 13'h0001};
    vt[5] = '{put(fill(13'h1FFE), 0, 13'h1FFF), 4'd0, 13'h1FFF};
    vt[6] = '{put(put(fill(13'h1000), 5, 13'h0FFF), 6, 13'h0FFF), 4'd5, 13'h0FFF};
    vt[7] = '{put(put(fill(13'h0000), 3, 13'h01FF), 10, 13'h0200), 4'd10, 13'h0200};

    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Single pixels: output must appear exactly 4 cycles after input
    for (int i = 0; i < 8; i++) begin
      in_enable = 1'b1; in_y = vt[i].y; in_vcnt = 2'd1; in_hcnt = 2'd1;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clock); #1;
        if (k == 1) in_enable = 1'b0;
        if (k == 3) check("vec_early_enable", 64'(out_enable), 64'd0);
      end
      check("vec_enable", 64'(out_enable), 64'd1);
      check("vec_class", 64'(out_class), 64'(vt[i].cls));
      check("vec_score", 64'(out_score), 64'(vt[i].score));
    end

    // Gapped stream 1,0,1,1
    add_pix(1'b1, 1, 2, 3);
    add_pix(1'b0, 3, 3, 5);
    add_pix(1'b1, 0, 1, 8);
    add_pix(1'b1, 2, 0, 11);
    run();
    check("gap_pulses", 64'(pulses), 64'd0);

    // Frame with class = hcnt
    e0 = '0;
    for (int u = 0; u < 4; u++) e0 = hput(e0, u, 5'd4);
    add_frame(0);
    run();
    check("frame0_pulses", 64'(pulses), 64'd1);
    check("frame0_hist", 64'(h0), 64'(e0));
    check("frame0_hold", 64'(out_hist), 64'(e0));

    // Next frame starts from zero
    e1 = '0;
    for (int u = 4; u < 8; u++) e1 = hput(e1, u, 5'd4);
    add_frame(1);
    run();
    check("frame1_pulses", 64'(pulses), 64'd1);
    check("frame1_hist", 64'(h1 | h0), 64'(e1));

    // Partial frame discarded by the next (0,0)
    for (int k = 0; k < 8; k++) add_pix(1'b1, k / 4, k % 4, 9);
    add_frame(0);
    run();
    check("partial_pulses", 64'(pulses), 64'd1);
    check("partial_hist", 64'(h0), 64'(e0));

    // Back-to-back frames
    add_frame(0);
    add_frame(2);
    run();
    e1 = hput(hput('0, 8, 5'd15), 11, 5'd1);
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_hist_a", 64'(h0), 64'(e0));
    check("b2b_hist_b", 64'(h1), 64'(e1));

    // Reset at pixel (2,1) of a frame
    for (int k = 0; k < 10; k++) begin
      in_enable = 1'b1; in_vcnt = 2'(k / 4); in_hcnt = 2'(k % 4); in_y = mk_y(CB'(k % 4));
      if (k == 9) rst = 1'b1;
      @(posedge clock); #1;
    end
    check_zero("midrst");
    rst = 1'b0;
    in_enable = 1'b0;
    for (int k = 0; k < 5; k++) add_pix(1'b1, 1, 1, 0);
    add_pix(1'b1, 3, 3, 0);
    run();
    check("midrst_pulses", 64'(pulses), 64'd1);
    check("midrst_hist", 64'(h0), 64'(hput('0, 0, 5'd6)));
    add_frame(3);
    run();
    check("after_rst_hist", 64'(h0), 64'(hput('0, 9, 5'd16)));

    // Saturation at 31
    for (int k = 0; k < 40; k++) add_pix(1'b1, 1, 1, 2);
    add_pix(1'b1, 3, 3, 2);
    run();
    check("sat_pulses", 64'(pulses), 64'd1);
    check("sat_hist", 64'(h0), 64'(hput('0, 2, 5'd31)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
